// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: one bit per cycle, done NB_DATA+1 cycles after start.
// Divider datapath is built only when MULDIV_DIVIDE_EN is defined; otherwise DIV/DIVU starts are ignored.
module ex_muldiv_unit #(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic               i_flush,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo,
    output logic               o_div_by_zero
);
    localparam int CW = $clog2(NB_DATA) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NB_DATA-1:0]   acc_q, acc_d, sh_q, sh_d, opb_q, opb_d;
    logic [NB_DATA-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                 sa_q, sa_d, sb_q, sb_d, done_q, done_d;
    logic                 a_neg, b_neg, start_ok;
    logic [NB_DATA-1:0]   a_mag, b_mag;
    logic [NB_DATA:0]     mul_sum;
    logic [2*NB_DATA-1:0] prod, prod_fix;

    // Signed ops work on magnitudes; the signs are re-applied in FIXUP.
    assign a_neg    = ~i_op[0] & i_data_a[NB_DATA-1];
    assign b_neg    = ~i_op[0] & i_data_b[NB_DATA-1];
    assign a_mag    = a_neg ? -i_data_a : i_data_a;
    assign b_mag    = b_neg ? -i_data_b : i_data_b;
    assign mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
    assign prod     = {acc_q, sh_q};
    assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;

`ifdef MULDIV_DIVIDE_EN
    logic             div_q, div_d, bz_q, bz_d, dbz_q, dbz_d;
    logic [NB_DATA:0] rem_sh, rem_diff;

    assign start_ok      = 1'b1;
    assign rem_sh        = {acc_q, sh_q[NB_DATA-1]};
    assign rem_diff      = rem_sh - {1'b0, opb_q};
    assign o_div_by_zero = dbz_q;
`else
    assign start_ok      = ~i_op[1];
    assign o_div_by_zero = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        opb_d   = opb_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULDIV_DIVIDE_EN
        div_d   = div_q;
        bz_d    = bz_q;
        dbz_d   = dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start && start_ok) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                    sh_d    = a_mag;
                    opb_d   = b_mag;
                    sa_d    = a_neg;
                    sb_d    = b_neg;
`ifdef MULDIV_DIVIDE_EN
                    div_d   = i_op[1];
                    bz_d    = (i_data_b == '0);
`endif
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NB_DATA - 1))
                    state_d = FIXUP;
                acc_d = mul_sum[NB_DATA:1];
                sh_d  = {mul_sum[0], sh_q[NB_DATA-1:1]};
`ifdef MULDIV_DIVIDE_EN
                // Restoring division: quotient bits shift into sh from the right.
                if (div_q) begin
                    if (!rem_diff[NB_DATA]) begin
                        acc_d = rem_diff[NB_DATA-1:0];
                        sh_d  = {sh_q[NB_DATA-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[NB_DATA-1:0];
                        sh_d  = {sh_q[NB_DATA-2:0], 1'b0};
                    end
                end
`endif
            end
            FIXUP: begin
                state_d      = IDLE;
                done_d       = 1'b1;
                {hi_d, lo_d} = prod_fix;
`ifdef MULDIV_DIVIDE_EN
                dbz_d = 1'b0;
                // A zero divisor leaves |A| as remainder, so the sign fix restores the raw dividend.
                if (div_q) begin
                    lo_d = (sa_q ^ sb_q) ? -sh_q : sh_q;
                    hi_d = sa_q ? -acc_q : acc_q;
                    if (bz_q) begin
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        if (i_flush) begin
            state_d = IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
`ifdef MULDIV_DIVIDE_EN
            dbz_d   = dbz_q;
`endif
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            opb_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            div_q   <= 1'b0;
            bz_q    <= 1'b0;
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            opb_q   <= opb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MULDIV_DIVIDE_EN
            div_q   <= div_d;
            bz_q    <= bz_d;
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign o_busy = (state_q != IDLE);
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: scoreboard of expected HI/LO/div-by-zero, checked at each o_done.
module tb_ex_muldiv_unit;
    logic        i_clock = 1'b0;
    logic        i_reset, i_start, i_flush;
    logic [1:0]  i_op;
    logic [31:0] i_data_a, i_data_b;
    logic        o_busy, o_done, o_div_by_zero;
    logic [31:0] o_hi, o_lo;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_hi_q[$];
    logic [31:0] exp_lo_q[$];
    logic        exp_dbz_q[$];
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    ex_muldiv_unit #(.NB_DATA(32), .NB_OP(2)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
        .i_data_a(i_data_a), .i_data_b(i_data_b), .i_flush(i_flush),
        .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo),
        .o_div_by_zero(o_div_by_zero)
    );

    always #5 i_clock = ~i_clock;

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint      p;
        logic [63:0] u;
        int          qi, ri;
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        case (op)
            2'd0: begin p = longint'($signed(a)) * longint'($signed(b)); {hi, lo} = p; end
            2'd1: begin u = {32'd0, a} * {32'd0, b}; {hi, lo} = u; end
            2'd2: begin
                if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; dbz = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = '0; end
                else begin qi = $signed(a) / $signed(b); ri = $signed(a) % $signed(b); lo = qi; hi = ri; end
            end
            default: begin
                if (b == 32'd0) begin lo = 32'hFFFF_FFFF; hi = a; dbz = 1'b1; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endfunction

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic        ed;
        model(op, a, b, eh, el, ed);
        exp_hi_q.push_back(eh);
        exp_lo_q.push_back(el);
        exp_dbz_q.push_back(ed);
        i_op = op; i_data_a = a; i_data_b = b; i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    // Called right after the start edge; returns cycles until o_done and busy cycles seen.
    task automatic wait_done(output int lat, output int busy_n, output bit seen);
        lat = 0; busy_n = 0; seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (o_done) begin seen = 1'b1; lat = k; break; end
            if (o_busy) busy_n++;
            step();
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_start = 1'b0; i_flush = 1'b0; i_op = 2'd0; i_data_a = '0; i_data_b = '0;
        repeat (3) step();
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", o_busy); end
        vectors++; if (o_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", o_done); end
        vectors++; if (o_hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi got %h want 0", o_hi); end
        vectors++; if (o_lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo got %h want 0", o_lo); end
        vectors++; if (o_div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz got %b want 0", o_div_by_zero); end
        i_reset = 1'b0;
        step();
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy got %b want 0", o_busy); end
    endtask

    task automatic test_mult();
        int lat, bn; bit seen;
        logic [31:0] eh, el; logic ed;
        issue(2'd0, 32'd7, 32'hFFFF_FFFD);
        wait_done(lat, bn, seen);
        eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front(); ed = exp_dbz_q.pop_front();
        vectors++; if (!seen) begin miscompares++; $display("FAIL mult_done_timeout got none want pulse"); end
        vectors++; if (lat != 33) begin miscompares++; $display("FAIL mult_latency got %0d want 33", lat); end
        vectors++; if (bn != 33) begin miscompares++; $display("FAIL mult_busy_cycles got %0d want 33", bn); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL mult_busy_at_done got %b want 0", o_busy); end
        vectors++; if (o_hi !== eh || eh !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi got %h want %h", o_hi, eh); end
        vectors++; if (o_lo !== el || el !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mult_lo got %h want %h", o_lo, el); end
        vectors++; if (o_div_by_zero !== ed) begin miscompares++; $display("FAIL mult_dbz got %b want %b", o_div_by_zero, ed); end
        last_hi = eh; last_lo = el;
        step();
        vectors++; if (o_done !== 1'b0) begin miscompares++; $display("FAIL mult_done_width got %b want 0", o_done); end
        vectors++; if (o_hi !== last_hi) begin miscompares++; $display("FAIL mult_hi_hold got %h want %h", o_hi, last_hi); end
    endtask

    // Each new op is started in the o_done cycle of the previous one.
    task automatic test_back_to_back();
        int lat, bn; bit seen;
        logic [31:0] eh, el; logic ed;
        logic [1:0]  top[8];
        logic [31:0] ta[8], tb[8];
        top = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0};
        ta  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'h0};
        tb  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h5, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h0};
        ta[6] = $urandom; tb[6] = $urandom; ta[7] = $urandom; tb[7] = $urandom;
        issue(top[0], ta[0], tb[0]);
        for (int i = 0; i < 8; i++) begin
            wait_done(lat, bn, seen);
            eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front(); ed = exp_dbz_q.pop_front();
            vectors++; if (!seen || lat != 33) begin miscompares++; $display("FAIL b2b_latency[%0d] got %0d seen=%0d want 33", i, lat, seen); end
            vectors++; if (o_hi !== eh || o_lo !== el) begin miscompares++; $display("FAIL b2b_result[%0d] got %h_%h want %h_%h", i, o_hi, o_lo, eh, el); end
            vectors++; if (o_div_by_zero !== ed) begin miscompares++; $display("FAIL b2b_dbz[%0d] got %b want %b", i, o_div_by_zero, ed); end
            last_hi = eh; last_lo = el;
            if (i < 7) issue(top[i+1], ta[i+1], tb[i+1]);
        end
        step();
    endtask

`ifdef MULDIV_DIVIDE_EN
    task automatic test_divide();
        int lat, bn; bit seen;
        logic [31:0] eh, el; logic ed;
        logic [1:0]  top[7];
        logic [31:0] ta[7], tb[7];
        top = '{2'd2, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3, 2'd2};
        ta  = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'd7, 32'h8000_0000, 32'h0, 32'h0};
        tb  = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 32'd0, 32'h0, 32'h0};
        ta[5] = $urandom; tb[5] = $urandom_range(1, 65535); ta[6] = $urandom; tb[6] = $urandom | 32'h1;
        for (int i = 0; i < 7; i++) begin
            issue(top[i], ta[i], tb[i]);
            wait_done(lat, bn, seen);
            eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front(); ed = exp_dbz_q.pop_front();
            vectors++; if (!seen || lat != 33) begin miscompares++; $display("FAIL div_latency[%0d] got %0d seen=%0d want 33", i, lat, seen); end
            vectors++; if (o_hi !== eh || o_lo !== el) begin miscompares++; $display("FAIL div_result[%0d] got %h_%h want %h_%h", i, o_hi, o_lo, eh, el); end
            vectors++; if (o_div_by_zero !== ed) begin miscompares++; $display("FAIL div_dbz[%0d] got %b want %b", i, o_div_by_zero, ed); end
            last_hi = eh; last_lo = el;
        end
        step();
    endtask
`else
    task automatic test_divide();
        bit any_busy, any_done;
        any_busy = 1'b0; any_done = 1'b0;
        i_op = 2'd3; i_data_a = 32'd100; i_data_b = 32'd0; i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (o_busy) any_busy = 1'b1;
            if (o_done) any_done = 1'b1;
            step();
        end
        vectors++; if (any_busy) begin miscompares++; $display("FAIL divu_ignored_busy got 1 want 0"); end
        vectors++; if (any_done) begin miscompares++; $display("FAIL divu_ignored_done got 1 want 0"); end
        vectors++; if (o_hi !== last_hi || o_lo !== last_lo) begin miscompares++; $display("FAIL divu_ignored_hilo got %h_%h want %h_%h", o_hi, o_lo, last_hi, last_lo); end
        vectors++; if (o_div_by_zero !== 1'b0) begin miscompares++; $display("FAIL divu_ignored_dbz got %b want 0", o_div_by_zero); end
    endtask
`endif

    task automatic test_flush();
        int lat, bn; bit seen, any_done;
        logic [31:0] eh, el; logic ed;
        issue(2'd1, 32'hDEAD_BEEF, 32'h0000_1234);
        for (int k = 0; k < 10; k++) step();
        vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL flush_busy_before got %b want 1", o_busy); end
        i_flush = 1'b1; i_start = 1'b1;
        step();
        i_flush = 1'b0; i_start = 1'b0;
        eh = exp_hi_q.pop_back(); el = exp_lo_q.pop_back(); ed = exp_dbz_q.pop_back();
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy_after got %b want 0", o_busy); end
        any_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (o_done || o_busy) any_done = 1'b1;
            step();
        end
        vectors++; if (any_done) begin miscompares++; $display("FAIL flush_no_done got activity want none"); end
        vectors++; if (o_hi !== last_hi || o_lo !== last_lo) begin miscompares++; $display("FAIL flush_hilo_kept got %h_%h want %h_%h", o_hi, o_lo, last_hi, last_lo); end
        i_op = 2'd0; i_flush = 1'b1; i_start = 1'b1;
        step();
        i_flush = 1'b0; i_start = 1'b0;
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL flush_beats_start got %b want 0", o_busy); end
        issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_done(lat, bn, seen);
        eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front(); ed = exp_dbz_q.pop_front();
        vectors++; if (!seen || lat != 33) begin miscompares++; $display("FAIL post_flush_latency got %0d seen=%0d want 33", lat, seen); end
        vectors++; if (o_hi !== eh || o_lo !== el) begin miscompares++; $display("FAIL post_flush_result got %h_%h want %h_%h", o_hi, o_lo, eh, el); end
        vectors++; if (o_div_by_zero !== ed) begin miscompares++; $display("FAIL post_flush_dbz got %b want %b", o_div_by_zero, ed); end
        last_hi = eh; last_lo = el;
        step();
    endtask

    task automatic test_reset_mid();
        bit any_done;
        logic [31:0] eh, el; logic ed;
        issue(2'd0, 32'hCAFE_0001, 32'h0BAD_F00D);
        for (int k = 0; k < 5; k++) step();
        eh = exp_hi_q.pop_back(); el = exp_lo_q.pop_back(); ed = exp_dbz_q.pop_back();
        i_reset = 1'b1;
        #1;
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy got %b want 0", o_busy); end
        vectors++; if (o_done !== 1'b0) begin miscompares++; $display("FAIL midreset_done got %b want 0", o_done); end
        vectors++; if (o_hi !== 32'd0 || o_lo !== 32'd0) begin miscompares++; $display("FAIL midreset_hilo got %h_%h want 0_0", o_hi, o_lo); end
        vectors++; if (o_div_by_zero !== 1'b0) begin miscompares++; $display("FAIL midreset_dbz got %b want 0", o_div_by_zero); end
        step();
        i_reset = 1'b0;
        last_hi = '0; last_lo = '0;
        any_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (o_done || o_busy) any_done = 1'b1;
            step();
        end
        vectors++; if (any_done) begin miscompares++; $display("FAIL midreset_no_result got activity want none"); end
        vectors++; if (o_hi !== 32'd0 || o_lo !== 32'd0) begin miscompares++; $display("FAIL midreset_hilo_after got %h_%h want 0_0", o_hi, o_lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_divide();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
